// File: rtl/apu_pkg.sv
// Shared APU definitions: length and duty lookup tables, register field layouts
// and small helpers used by the pulse and noise channels.
package apu_pkg;

  // Length counter load values, indexed by WR3[7:3].
  localparam logic [7:0] LEN_TABLE [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  // Step 0 of each pattern is the leftmost (most significant) bit.
  localparam logic [7:0] DUTY_TABLE [0:3] = '{
    8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111
  };

  localparam int WR0_DUTY_LSB  = 6;
  localparam int WR0_HALT_BIT  = 5;
  localparam int WR0_CONST_BIT = 4;
  localparam int WR1_EN_BIT    = 7;
  localparam int WR1_PER_LSB   = 4;
  localparam int WR1_NEG_BIT   = 3;
  localparam int WR3_LEN_LSB   = 3;

  // Packed layouts mirror the bit positions above so a bus byte casts directly.
  typedef struct packed {
    logic [1:0] duty;
    logic       halt;
    logic       const_vol;
    logic [3:0] vol;
  } ctrl_t;

  typedef struct packed {
    logic       en;
    logic [2:0] per;
    logic       neg;
    logic [2:0] shift;
  } sweep_t;

  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] step);
    logic [7:0] pattern;
    pattern = DUTY_TABLE[duty];
    return pattern[3'd7 - step];
  endfunction

endpackage

// File: rtl/apu_envelope.sv
// Envelope generator: divider, decay level and start flag, clocked by the
// quarter-frame strobe. Shared between the pulse and noise channels.
module apu_envelope
  import apu_pkg::*;
#(
  parameter int VOL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quarter,
  input  logic             start_set,
  input  logic             loop,
  input  logic [VOL_W-1:0] period,
  output logic [VOL_W-1:0] decay
);

  localparam logic [VOL_W-1:0] DECAY_MAX = '1;
  localparam logic [VOL_W-1:0] ONE       = VOL_W'(1);

  logic             start;
  logic [VOL_W-1:0] divider;

  // A start request arriving with a quarter frame is only acted on next quarter frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start   <= 1'b0;
      divider <= '0;
      decay   <= '0;
    end else begin
      if (quarter) begin
        if (start) begin
          start   <= 1'b0;
          decay   <= DECAY_MAX;
          divider <= period;
        end else if (divider == '0) begin
          divider <= period;
          if (decay != '0) begin
            decay <= decay - ONE;
          end else if (loop) begin
            decay <= DECAY_MAX;
          end
        end else begin
          divider <= divider - ONE;
        end
      end
      if (start_set) begin
        start <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_chan_p.sv
// APU pulse channel: period timer, 8-step duty sequencer, length counter,
// frequency sweep and envelope feeding a VOL_W-bit sample.
module pulse_chan_p
  import apu_pkg::*;
#(
  parameter int TIMER_W    = 11,
  parameter int VOL_W      = 4,
  parameter int CARRY_MODE = 0
) (
  input  logic             ACLK,
  input  logic             n_RES,
  input  logic [7:0]       DB,
  input  logic             WR0,
  input  logic             WR1,
  input  logic             WR2,
  input  logic             WR3,
  input  logic             nLFO1,
  input  logic             nLFO2,
  input  logic             NOSQ,
  input  logic             LOCK,
  output logic             SQ_LC,
  output logic [VOL_W-1:0] SQ_OUT
);

  localparam int                 HI_W       = TIMER_W - 8;
  localparam logic [TIMER_W-1:0] T_ONE      = TIMER_W'(1);
  localparam logic [TIMER_W:0]   W_ONE      = (TIMER_W + 1)'(1);
  localparam logic [TIMER_W-1:0] MIN_PERIOD = TIMER_W'(8);

  logic [1:0]         rst_sync;
  logic               rst_n;
  ctrl_t              ctrl;
  sweep_t             sweep;
  logic [TIMER_W-1:0] period;
  logic [TIMER_W-1:0] period_nxt;
  logic [TIMER_W-1:0] timer;
  logic [2:0]         step;
  logic [7:0]         len;
  logic [2:0]         sweep_div;
  logic               sweep_reload;
  logic [TIMER_W:0]   p_ext;
  logic [TIMER_W:0]   shifted;
  logic [TIMER_W:0]   target;
  logic               mute;
  logic               sweep_upd;
  logic               quarter;
  logic               half;
  logic [VOL_W-1:0]   decay;
  logic [VOL_W-1:0]   vol_sel;

  assign quarter = ~nLFO1;
  assign half    = ~nLFO2;

  // Reset asserts immediately but releases two ACLK edges after n_RES rises.
  always_ff @(posedge ACLK or negedge n_RES) begin
    if (!n_RES) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  always_comb begin
    p_ext   = {1'b0, period};
    shifted = p_ext >> sweep.shift;
    target  = p_ext + shifted;
    if (sweep.neg) begin
      if (CARRY_MODE != 0) begin
        target = p_ext - shifted;
      end else if (p_ext > shifted) begin
        target = p_ext - shifted - W_ONE;
      end else begin
        target = '0;
      end
    end
  end

  assign mute      = (period < MIN_PERIOD) || (!sweep.neg && target[TIMER_W]);
  assign sweep_upd = half && (sweep_div == 3'd0) && sweep.en && (sweep.shift != 3'd0) && !mute;

  // Bus writes land after a sweep update so a same-cycle write always wins.
  always_comb begin
    period_nxt = period;
    if (sweep_upd) begin
      period_nxt = target[TIMER_W-1:0];
    end
    if (WR2) begin
      period_nxt[7:0] = DB;
    end
    if (WR3) begin
      period_nxt[TIMER_W-1:8] = DB[HI_W-1:0];
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      ctrl   <= '0;
      sweep  <= '0;
      period <= '0;
    end else begin
      if (WR0) begin
        ctrl <= ctrl_t'(DB);
      end
      if (WR1) begin
        sweep <= sweep_t'(DB);
      end
      period <= period_nxt;
    end
  end

  // The timer reloads from the registered period, so new periods apply next reload.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      step  <= 3'd0;
    end else begin
      if (timer == '0) begin
        timer <= period;
        step  <= step + 3'd1;
      end else begin
        timer <= timer - T_ONE;
      end
      if (WR3) begin
        step <= 3'd0;
      end
    end
  end

  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      len <= 8'd0;
    end else if (NOSQ) begin
      len <= 8'd0;
    end else if (WR3) begin
      len <= LEN_TABLE[DB[7:WR3_LEN_LSB]];
    end else if (half && (len != 8'd0) && !ctrl.halt && !LOCK) begin
      len <= len - 8'd1;
    end
  end

  // A WR1 coinciding with a half frame leaves the reload pending for the next one.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      sweep_div    <= 3'd0;
      sweep_reload <= 1'b0;
    end else begin
      if (half) begin
        if ((sweep_div == 3'd0) || sweep_reload) begin
          sweep_div    <= sweep.per;
          sweep_reload <= 1'b0;
        end else begin
          sweep_div <= sweep_div - 3'd1;
        end
      end
      if (WR1) begin
        sweep_reload <= 1'b1;
      end
    end
  end

  apu_envelope #(
    .VOL_W(VOL_W)
  ) u_env (
    .clk      (ACLK),
    .rst_n    (rst_n),
    .quarter  (quarter),
    .start_set(WR3),
    .loop     (ctrl.halt),
    .period   (VOL_W'(ctrl.vol)),
    .decay    (decay)
  );

  always_comb begin
    vol_sel = ctrl.const_vol ? VOL_W'(ctrl.vol) : decay;
    SQ_OUT  = '0;
    if (!mute && (len != 8'd0) && duty_bit(ctrl.duty, step)) begin
      SQ_OUT = vol_sel;
    end
  end

  assign SQ_LC = (len != 8'd0);

endmodule

// File: doc/pulse_chan_p.md
# pulse_chan_p

Parametrised pulse (square) wave channel for the APU: an 8-step duty sequencer driven by a programmable period timer, with envelope, length counter and frequency sweep. The sweep negate arithmetic is selectable, so one RTL source serves both pulse channels. Register writes arrive on the APU data bus via per-register strobes. Frame-sequencer strobes clock the slow units, and the 4-bit-wide (`VOL_W`) output feeds the DAC/mixer.

## Interface
Parameters:
- `TIMER_W`, 11: period/timer width; legal 9..11.
- `VOL_W`, 4: volume/envelope width.
- `CARRY_MODE`, 0: sweep negate arithmetic. 0 = ones' complement (target = P − (P>>s) − 1); 1 = two's complement (target = P − (P>>s)).

Ports (one clock; reset is asynchronous and active-low):
- `ACLK`  in  1  APU clock; all state updates on its rising edge.
- `n_RES`  in  1  asynchronous active-low reset.
- `DB`  in  8  register write data.
- `WR0`..`WR3`  in  1 each  register write strobes, one ACLK wide.
- `nLFO1`  in  1  quarter-frame strobe, active low, one ACLK.
- `nLFO2`  in  1  half-frame strobe, active low, one ACLK.
- `NOSQ`  in  1  channel disabled: length counter held at 0.
- `LOCK`  in  1  debug freeze of the length counter.
- `SQ_LC`  out  1  length counter ≠ 0.
- `SQ_OUT`  out  `VOL_W`  channel sample.

## Operation
- **WR0:** DB[7:6] duty, DB[5] halt/loop, DB[4] constant volume, DB[3:0] volume or envelope period.
- **WR1:** DB[7] sweep enable, DB[6:4] sweep period, DB[3] negate, DB[2:0] shift. Also sets `sweep_reload`.
- **WR2:** period[7:0].
- **WR3:** DB[7:3] length index; DB[TIMER_W−9:0] period high bits. The write also:
  - resets the duty step to 0;
  - sets `env_start`;
  - loads the length counter with `LEN_TABLE[idx]` when `NOSQ`=0.
- **Timer:** down-counter. At 0 it reloads the period and advances the duty step (mod 8); otherwise it decrements by 1 every ACLK.
- **Envelope (`nLFO1` low):**
  - If `env_start`: clear it, set decay = 2^VOL_W−1, and reload the divider.
  - Otherwise, when the divider reaches 0: reload the divider and decrement decay. At decay 0, decay wraps to max if loop is set, else holds at 0.
  - Otherwise: decrement the divider.
- **Length (`nLFO2` low):** decrements when ≠0, halt=0 and `LOCK`=0. `NOSQ`=1 forces the counter to 0 continuously.
- **Sweep (`nLFO2` low):**
  - If divider=0, enable=1, shift≠0 and not muted: period ← target.
  - Then, if divider=0 or `sweep_reload`: divider ← sweep period and clear `sweep_reload`; else decrement the divider.
- **Sweep target:** computed in TIMER_W+1 bits.
  - Add mode: P + (P>>s).
  - Negate mode: per `CARRY_MODE`, clamped at 0.
- **Mute:** P < 8, or (negate=0 and target bit TIMER_W set). Mute is evaluated even when the sweep is disabled.
- **`SQ_OUT`:** 0 if mute, length=0, or `DUTY_TABLE[duty][step]`=0. Otherwise it is the constant volume or the decay value.

## Timing
- Reset: every register, counter, flag and step is 0. `SQ_OUT`=0 and `SQ_LC`=0.
- Release of `n_RES` is synchronised internally with a 2-flop synchroniser.
- A write is visible in state on the ACLK edge that samples `WRx`=1.
- Outputs are combinational from registered state, so they reflect a write one edge after the strobe.
- Timer period is P+1 ACLKs per duty step; a full waveform is 8(P+1) ACLKs.
- A WR2/WR3 in the same cycle the timer hits 0: the reload uses the old period, and the new period applies from the next reload.
- WR3 together with `nLFO2`: the load wins and no decrement happens that cycle.
- WR3 together with `nLFO1`: `env_start` is set and the envelope does not restart until the next quarter frame.
- WR1 together with `nLFO2`: the sweep step uses the old settings, and the reload flag is set for the next half frame.
- A sweep update of the period takes effect at the next timer reload.
- Reset asserted mid-operation: immediate return to reset values, regardless of ACLK.

## Structure
- Shared package `apu_pkg`:
  - `LEN_TABLE[32]` (8-bit entries);
  - `DUTY_TABLE[4]` = 01000000, 01100000, 01111000, 10011111;
  - register field position constants.
- Sub-module `apu_envelope` holds the divider, decay and start flag. It is parametrised by `VOL_W` and reused by the noise channel.
- Timer, sequencer, length and sweep stay in this module.

## Test plan
- **Reset:** hold `n_RES` low while toggling all inputs -> `SQ_OUT`=0, `SQ_LC`=0. Release -> still 0 until a WR3.
- **Waveform:** WR0=0xBF (duty 2, const vol 15), WR2=0x08, WR3=0x08 (idx 1 → 254) -> `SQ_LC`=1. `SQ_OUT` is 15 for 4 steps and 0 for 4 steps, each step 9 ACLKs, period 72.
- **Length:** WR0 halt=0, WR3 idx 0 (10) -> 10 `nLFO2` pulses bring `SQ_LC` to 0. Repeat with `LOCK`=1 -> no decrement. `NOSQ`=1 -> immediate 0.
- **Envelope:** WR0=0x01 then WR3, then quarter frames -> decay 15,15,14,14,…,0 and holds at 0. With loop=1 -> wraps to 15.
- **Sweep negate:** P=0x100, shift 1, negate, sweep period 0 -> next half frame gives P=0x7F with `CARRY_MODE`=0, or 0x80 with `CARRY_MODE`=1.
- **Sweep mute:** P=0x600, shift 1, add -> target 0x900 > 0x7FF, so `SQ_OUT`=0 even with the sweep disabled. Also P=7 -> muted.
